// File: rtl/pht_predictor.sv
// Global-history (gshare-style) pattern history table: 2-bit saturating counters
// indexed by PC XOR history, one registered prediction and one update per cycle.
module pht_predictor #(
    parameter int INDEX_WIDTH = 5,
    parameter int GHR_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_req,
    input  logic [15:0]            pred_pc,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    output logic [GHR_WIDTH-1:0]   ghr
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] hash_index(
        input logic [INDEX_WIDTH-1:0] pc_bits,
        input logic [GHR_WIDTH-1:0]   hist
    );
        return pc_bits ^ INDEX_WIDTH'(hist);
    endfunction

    logic [1:0]             r_pht [ENTRIES];
    logic [GHR_WIDTH-1:0]   r_ghr;
    logic                   r_pred_valid;
    logic                   r_pred_taken;
    logic [INDEX_WIDTH-1:0] r_pred_index;

    logic [INDEX_WIDTH-1:0] w_lookup_index;
    logic [1:0]             w_lookup_ctr;
    logic                   w_pc_unused;

    // Byte-offset bit and high PC bits do not participate in the hash.
    assign w_pc_unused    = ^{pred_pc[15:INDEX_WIDTH+1], pred_pc[0]};

    // Lookup reads current (pre-update) table and history: read-before-write.
    assign w_lookup_index = hash_index(pred_pc[INDEX_WIDTH:1], r_ghr);
    assign w_lookup_ctr   = r_pht[w_lookup_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_pht[i] <= 2'b01;
        end else if (upd_valid) begin
            r_pht[upd_index] <= ctr_next(r_pht[upd_index], upd_taken);
        end
    end

    // History advances only when a branch resolves, never on prediction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (upd_valid)
            r_ghr <= GHR_WIDTH'({r_ghr, upd_taken});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
        end else begin
            r_pred_valid <= pred_req;
            if (pred_req) begin
                r_pred_taken <= w_lookup_ctr[1];
                r_pred_index <= w_lookup_index;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_index = r_pred_index;
    assign ghr        = r_ghr;

endmodule

// File: tb/tb_pht_predictor.sv
// Directed bench for pht_predictor: stimulus pushes expected predictions into a
// queue, a negedge monitor pops and compares them whenever pred_valid is seen.
module tb_pht_predictor;

    localparam int IW = 5;
    localparam int GW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pred_req = 1'b0;
    logic [15:0]   pred_pc = '0;
    logic          pred_valid;
    logic          pred_taken;
    logic [IW-1:0] pred_index;
    logic          upd_valid = 1'b0;
    logic [IW-1:0] upd_index = '0;
    logic          upd_taken = 1'b0;
    logic [GW-1:0] ghr;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          taken;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    pht_predictor #(.INDEX_WIDTH(IW), .GHR_WIDTH(GW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_req   (pred_req),
        .pred_pc    (pred_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .ghr        (ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every visible prediction must match the oldest expected entry.
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pred_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pred_index", 32'(pred_index), 32'(e.idx));
                chk("pred_taken", 32'(pred_taken), 32'(e.taken));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic [15:0] pc, input logic [IW-1:0] idx, input logic t);
        exp_q.push_back('{idx: idx, taken: t});
        pred_req = 1'b1;
        pred_pc  = pc;
        step();
        pred_req = 1'b0;
    endtask

    task automatic update(input logic [IW-1:0] idx, input logic t);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = t;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset with active requests that must be ignored.
        #1;
        rst       = 1'b1;
        pred_req  = 1'b1;
        pred_pc   = 16'h0040;
        upd_valid = 1'b1;
        upd_index = '0;
        upd_taken = 1'b1;
        #1;
        chk("rst_async_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_async_ghr", 32'(ghr), 32'd0);
        step();
        step();
        chk("rst_hold_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_hold_pred_index", 32'(pred_index), 32'd0);
        chk("rst_hold_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_hold_ghr", 32'(ghr), 32'd0);
        rst       = 1'b0;
        pred_req  = 1'b0;
        upd_valid = 1'b0;

        // Post-reset lookup on the first edge after release.
        predict(16'h0040, 5'd0, 1'b0);
        chk("post_reset_ghr", 32'(ghr), 32'd0);

        // Training entry 0 and history hashing.
        update(5'd0, 1'b1);
        update(5'd0, 1'b1);
        chk("train_ghr", 32'(ghr), 32'd3);
        predict(16'h0006, 5'd0, 1'b1);

        // Saturation at 00 on entry 5.
        update(5'd5, 1'b0);
        chk("sat_ghr_after_first", 32'(ghr), 32'd6);
        predict(16'h0006, 5'd5, 1'b0);
        update(5'd5, 1'b0);
        update(5'd5, 1'b0);
        update(5'd5, 1'b1);
        predict(16'h0008, 5'd5, 1'b0);
        chk("sat_ghr_after_taken", 32'(ghr), 32'd1);

        // Saturation at 11 on entry 0, confirmed by walking down.
        update(5'd0, 1'b1);
        update(5'd0, 1'b1);
        update(5'd0, 1'b1);
        chk("sat_hi_ghr", 32'(ghr), 32'd7);
        predict(16'h000E, 5'd0, 1'b1);
        update(5'd0, 1'b0);
        predict(16'h000C, 5'd0, 1'b1);
        update(5'd0, 1'b0);
        predict(16'h0008, 5'd0, 1'b0);

        // Same-cycle update and prediction on entry 0 (01 -> 10).
        exp_q.push_back('{idx: 5'd0, taken: 1'b0});
        pred_req  = 1'b1;
        pred_pc   = 16'h0008;
        upd_valid = 1'b1;
        upd_index = 5'd0;
        upd_taken = 1'b1;
        step();
        pred_req  = 1'b0;
        upd_valid = 1'b0;
        chk("collision_ghr", 32'(ghr), 32'd1);
        predict(16'h0008, 5'd5, 1'b0);
        predict(16'h0002, 5'd0, 1'b1);

        // Idle hold.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_pred_valid", 32'(pred_valid), 32'd0);
            chk("idle_pred_taken", 32'(pred_taken), 32'd1);
            chk("idle_pred_index", 32'(pred_index), 32'd0);
        end
        predict(16'h0002, 5'd0, 1'b1);

        // Build ghr=101 with an in-flight prediction, then reset between edges.
        update(5'd9, 1'b0);
        update(5'd9, 1'b1);
        pred_req = 1'b1;
        pred_pc  = 16'h0000;
        step();
        pred_req = 1'b0;
        chk("pre_rst_pred_valid", 32'(pred_valid), 32'd1);
        chk("pre_rst_pred_index", 32'(pred_index), 32'd5);
        chk("pre_rst_ghr", 32'(ghr), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("mid_rst_pred_index", 32'(pred_index), 32'd0);
        chk("mid_rst_ghr", 32'(ghr), 32'd0);
        step();
        rst = 1'b0;

        // Every entry back at weak-not-taken.
        for (int i = 0; i < 32; i++)
            predict(16'(i << 1), 5'(i), 1'b0);
        update(5'd3, 1'b1);
        predict(16'h0004, 5'd3, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
